// File: rtl/que_pkg.sv
// Shared constants and pointer helpers for the double-ended queue.
package que_pkg;

    localparam int QUE_WIDTH = 4;
    localparam int QUE_DEPTH = 4;

    // Width of the occupancy counter for the default depth (0..DEPTH inclusive).
    typedef logic [$clog2(QUE_DEPTH+1)-1:0] count_t;

    // Advance a circular pointer; wraps from depth-1 back to 0.
    function automatic int ptr_inc(input int p, input int depth);
        return (p == depth - 1) ? 0 : p + 1;
    endfunction

    // Retreat a circular pointer; wraps from 0 to depth-1.
    function automatic int ptr_dec(input int p, input int depth);
        return (p == 0) ? depth - 1 : p - 1;
    endfunction

endpackage

// File: rtl/que_ptr.sv
// Circular pointer register: increments, decrements or holds with wrap at DEPTH.
module que_ptr
    import que_pkg::*;
#(
    parameter int DEPTH = QUE_DEPTH,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] ptr_next;

    // Simultaneous inc and dec cancel out, so the pointer holds.
    always_comb begin
        ptr_next = ptr;
        if (inc && !dec) begin
            ptr_next = PW'(ptr_inc(int'(ptr), DEPTH));
        end else if (dec && !inc) begin
            ptr_next = PW'(ptr_dec(int'(ptr), DEPTH));
        end
    end

    // Pointer register with synchronous reset to slot 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/que_drain.sv
// Double-ended queue: push at either end, pop one word per cycle from either
// end under valid/ready, with a front-to-back snapshot of the contents.
module que_drain
    import que_pkg::*;
#(
    parameter int WIDTH = QUE_WIDTH,
    parameter int DEPTH = QUE_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_front,
    input  logic                       push_back,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_back,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf,
    output logic [WIDTH-1:0]           out [DEPTH]
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    head_dec;
    logic [PW-1:0]    tail_dec;

    logic             pop;
    logic             pop_front;
    logic             pop_back;
    logic [CW:0]      free;
    logic [CW:0]      need;
    logic             admit;
    logic             drop;
    logic             pf_ok;
    logic             pb_ok;
    logic [PW-1:0]    wf_idx;
    logic [PW-1:0]    wb_idx;
    logic [CW-1:0]    count_next;
    logic [PW-1:0]    snap_idx [DEPTH];

    assign rd_valid = (count != '0);
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));

    assign head_dec = PW'(ptr_dec(int'(head), DEPTH));
    assign tail_dec = PW'(ptr_dec(int'(tail), DEPTH));

    // Pop qualification and all-or-nothing push admission; a pop in the same
    // cycle frees one slot, so a full queue can still take a push alongside a pop.
    always_comb begin
        pop       = rd_valid && rd_ready;
        pop_front = pop && !rd_back;
        pop_back  = pop && rd_back;
        free      = (CW+1)'(DEPTH) - {1'b0, count} + {{CW{1'b0}}, pop};
        need      = {{CW{1'b0}}, push_front} + {{CW{1'b0}}, push_back};
        admit     = (need <= free);
        drop      = (need != '0) && !admit;
        pf_ok     = push_front && admit;
        pb_ok     = push_back && admit;
        // Same-end pop+push reuses the popped slot instead of moving the pointer.
        wf_idx    = pop_front ? head : head_dec;
        wb_idx    = pop_back ? tail_dec : tail;
        count_next = count + CW'(pf_ok) + CW'(pb_ok) - CW'(pop);
    end

    que_ptr #(.DEPTH(DEPTH), .PW(PW)) u_head (
        .clk (clk),
        .rst (rst),
        .inc (pop_front),
        .dec (pf_ok),
        .ptr (head)
    );

    que_ptr #(.DEPTH(DEPTH), .PW(PW)) u_tail (
        .clk (clk),
        .rst (rst),
        .inc (pb_ok),
        .dec (pop_back),
        .ptr (tail)
    );

    // Storage write; both pushes may land in one cycle with the same word.
    // Contents are not cleared on reset since count gates every read.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((pf_ok && (PW'(i) == wf_idx)) || (pb_ok && (PW'(i) == wb_idx))) begin
                    mem[i] <= wr_data;
                end
            end
        end
    end

    // Occupancy counter and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            count <= count_next;
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

    // Read port: front or back entry, forced to zero when empty.
    always_comb begin
        rd_data = '0;
        if (rd_valid) begin
            rd_data = rd_back ? mem[tail_dec] : mem[head];
        end
    end

    // Snapshot slot index for each position counted from the front.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(head) + i >= DEPTH) begin
                snap_idx[i] = PW'(int'(head) + i - DEPTH);
            end else begin
                snap_idx[i] = PW'(int'(head) + i);
            end
        end
    end

    // Front-to-back snapshot; positions past the occupancy read as zero.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            out[i] = (i < int'(count)) ? mem[snap_idx[i]] : '0;
        end
    end

endmodule

// File: tb/tb_que_drain.sv
// Directed bench for que_drain at WIDTH=4, DEPTH=4.
module tb_que_drain;
    import que_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         push_front;
    logic         push_back;
    logic [3:0]   wr_data;
    logic         rd_back;
    logic         rd_ready;
    logic         rd_valid;
    logic [3:0]   rd_data;
    count_t       count;
    logic         full;
    logic         empty;
    logic         ovf;
    logic [3:0]   out_v [4];

    int n_cmp = 0;
    int n_bad = 0;

    que_drain #(.WIDTH(4), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .push_front (push_front),
        .push_back  (push_back),
        .wr_data    (wr_data),
        .rd_back    (rd_back),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .ovf        (ovf),
        .out        (out_v)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] e0, input logic [3:0] e1,
                             input logic [3:0] e2, input logic [3:0] e3);
        logic [3:0] exp [4];
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_out%0d", tag, i), 32'(out_v[i]), 32'(exp[i]));
        end
    endtask

    initial begin
        rst = 1'b1; push_front = 1'b0; push_back = 1'b0; wr_data = '0;
        rd_back = 1'b0; rd_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_valid", 32'(rd_valid), 0);
        check("rst_rdata", 32'(rd_data), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_count", 32'(count), 0);
        check("rst_ovf", 32'(ovf), 0);
        check_out("rst", 0, 0, 0, 0);

        // push_back 2, 3
        push_back = 1'b1; wr_data = 4'd2; step();
        wr_data = 4'd3; step();
        push_back = 1'b0;
        check_out("pb23", 2, 3, 0, 0);
        check("pb23_count", 32'(count), 2);
        rd_back = 1'b0; #1;
        check("pb23_front", 32'(rd_data), 2);
        rd_back = 1'b1; #1;
        check("pb23_back", 32'(rd_data), 3);
        rd_back = 1'b0;

        // push_front 6, 9 then overflowing push_back 8
        push_front = 1'b1; wr_data = 4'd6; step();
        wr_data = 4'd9; step();
        push_front = 1'b0;
        check("pf_full", 32'(full), 1);
        push_back = 1'b1; wr_data = 4'd8; step();
        push_back = 1'b0;
        check("ovf_set", 32'(ovf), 1);
        check("ovf_full", 32'(full), 1);
        check("ovf_count", 32'(count), 4);
        check_out("ovf", 9, 6, 2, 3);

        // Full queue: front pop with push_back 12 in the same cycle
        rd_back = 1'b0; rd_ready = 1'b1; push_back = 1'b1; wr_data = 4'd12;
        #1;
        check("popf_rdata", 32'(rd_data), 9);
        step();
        push_back = 1'b0; rd_ready = 1'b0;
        check_out("popf_pb", 6, 2, 3, 12);
        check("popf_count", 32'(count), 4);
        check("popf_ovf", 32'(ovf), 1);

        // Drain from the back for 5 cycles
        rd_back = 1'b1; rd_ready = 1'b1; #1;
        check("drain0", 32'(rd_data), 12); step();
        check("drain1", 32'(rd_data), 3);  step();
        check("drain2", 32'(rd_data), 2);  step();
        check("drain3", 32'(rd_data), 6);  step();
        check("drain4_valid", 32'(rd_valid), 0); step();
        rd_ready = 1'b0;
        check("drain_valid", 32'(rd_valid), 0);
        check("drain_rdata", 32'(rd_data), 0);
        check("drain_empty", 32'(empty), 1);
        check("drain_count", 32'(count), 0);

        // Alternating push_back k / front pop, wrapping the pointers
        rd_back = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            push_back = 1'b1; wr_data = 4'(k); step();
            push_back = 1'b0;
            check($sformatf("wrap_rd%0d", k), 32'(rd_data), 32'(k));
            check($sformatf("wrap_cnt%0d", k), 32'(count), 1);
            rd_ready = 1'b1; step();
            rd_ready = 1'b0;
        end
        check("wrap_empty", 32'(empty), 1);

        // Both pushes together from empty, then one more push_back
        push_front = 1'b1; push_back = 1'b1; wr_data = 4'd5; step();
        push_front = 1'b0; push_back = 1'b0;
        check("both_count", 32'(count), 2);
        check_out("both", 5, 5, 0, 0);
        push_back = 1'b1; wr_data = 4'd7; step();
        check("pre_rst_count", 32'(count), 3);
        check_out("pre_rst", 5, 5, 7, 0);

        // Reset with a push active
        rst = 1'b1; wr_data = 4'd1; step();
        rst = 1'b0; push_back = 1'b0;
        #1;
        check("rst2_count", 32'(count), 0);
        check("rst2_ovf", 32'(ovf), 0);
        check("rst2_empty", 32'(empty), 1);
        check_out("rst2", 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
